// File: rtl/demux_1_4_pkg.sv
// Shared types and the select decoder for the registered 1-to-4 demux.
// Latency: n/a (types and a combinational helper only).
// Backpressure: none; the demux takes a new select/enable pair every cycle.
package demux_1_4_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned OUT_N = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_N-1:0] onehot_t;

    // One-hot decode of sel, gated by en; all-zero when en is low.
    function automatic onehot_t decode(input sel_t sel, input logic en);
        onehot_t hot;
        hot = '0;
        if (en) begin
            hot[sel] = 1'b1;
        end
        return hot;
    endfunction

endpackage : demux_1_4_pkg

// File: rtl/demux_1_4_hit_cnt.sv
// One saturating hit counter: holds at all-ones instead of wrapping; clr beats inc.
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none; inc is accepted every cycle.
module demux_1_4_hit_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : demux_1_4_hit_cnt

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demux: e is steered to output line a, others low; optional hit counters (DEMUX_1_4_HIT_CNT_EN).
// Latency: 1 cycle from a/e to c (and to cnt when counters are built).
// Backpressure: none; a new a/e pair is accepted every cycle.
module demux_1_4
    import demux_1_4_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   a,
    input  logic               e,
    output logic [OUT_N-1:0]   c
`ifdef DEMUX_1_4_HIT_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [OUT_N*CNT_W-1:0] cnt
`endif
);

    // Counter width must stay within 1..16; an out-of-range value leaves this
    // block without a name, which shows up as an elaboration difference.
    if ((CNT_W >= 1) && (CNT_W <= 16)) begin : g_cnt_w_ok
    end

    onehot_t c_d;
    onehot_t c_q;

    // Decode the sampled select/enable into the next one-hot output.
    always_comb begin
        c_d = decode(sel_t'(a), e);
    end

    // Output register; reset drops all strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;

`ifdef DEMUX_1_4_HIT_CNT_EN
    // Each counter is bumped by the same decoded value that loads c, so c and
    // cnt always describe the same sampled inputs.
    for (genvar i = 0; i < OUT_N; i++) begin : g_hit_cnt
        demux_1_4_hit_cnt #(
            .CNT_W (CNT_W)
        ) u_hit_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (c_d[i]),
            .clr   (cnt_clr),
            .cnt   (cnt[i*CNT_W +: CNT_W])
        );
    end
`endif

endmodule : demux_1_4

// File: tb/tb_demux_1_4.sv
// Directed bench for demux_1_4: default-width and 2-bit-counter instances share stimulus.
// Latency: checks c/cnt 1 ns after each rising edge.
// Backpressure: n/a.
module tb_demux_1_4;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic       e;
    logic [3:0] c8;
    logic [3:0] c2;
`ifdef DEMUX_1_4_HIT_CNT_EN
    logic        cnt_clr;
    logic [31:0] cnt8;
    logic [7:0]  cnt2;
`endif

    int checks;
    int errors;

    demux_1_4 #(.CNT_W(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .e       (e),
        .c       (c8)
`ifdef DEMUX_1_4_HIT_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt     (cnt8)
`endif
    );

    demux_1_4 #(.CNT_W(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .e       (e),
        .c       (c2)
`ifdef DEMUX_1_4_HIT_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt     (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_hot [4];

    initial begin
        exp_hot[0] = 4'b0001;
        exp_hot[1] = 4'b0010;
        exp_hot[2] = 4'b0100;
        exp_hot[3] = 4'b1000;
        checks = 0;
        errors = 0;

        rst_n = 1'b0;
        e     = 1'b1;
        a     = 2'd2;
`ifdef DEMUX_1_4_HIT_CNT_EN
        cnt_clr = 1'b0;
`endif
        step();
        step();
        chk("rst_c8", 32'(c8), 32'h0);
        chk("rst_c2", 32'(c2), 32'h0);
`ifdef DEMUX_1_4_HIT_CNT_EN
        chk("rst_cnt8", cnt8, 32'h0);
        chk("rst_cnt2", 32'(cnt2), 32'h0);
`endif

        rst_n = 1'b1;
        step();
        chk("rel_c8", 32'(c8), 32'h4);
        chk("rel_c2", 32'(c2), 32'h4);

        // Disabled sweep: no line may be driven.
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            step();
            chk($sformatf("dis_a%0d", i), 32'(c8), 32'h0);
        end

        // Enabled sweep: exactly bit a set.
        e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            step();
            chk($sformatf("en_a%0d", i), 32'(c8), 32'(exp_hot[i]));
            chk($sformatf("en2_a%0d", i), 32'(c2), 32'(exp_hot[i]));
        end

`ifdef DEMUX_1_4_HIT_CNT_EN
        // Clear with no hit, then 5 hits on line 3 and 2 on line 1.
        e = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt8", cnt8, 32'h0);
        chk("clr_cnt2", 32'(cnt2), 32'h0);
        e = 1'b1;
        a = 2'd3;
        repeat (5) step();
        chk("hit3_c", 32'(c8), 32'h8);
        a = 2'd1;
        repeat (2) step();
        chk("hit1_c", 32'(c8), 32'h2);
        chk("hits_cnt8", cnt8, 32'h05000200);
        chk("hits_cnt2", 32'(cnt2), 32'h000000C8);
        e = 1'b0;
        step();
        chk("hold_cnt8", cnt8, 32'h05000200);

        // Saturation: 6 hits on line 0.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        e = 1'b1;
        a = 2'd0;
        repeat (6) step();
        chk("sat_cnt2", 32'(cnt2), 32'h00000003);
        chk("sat_cnt8", cnt8, 32'h00000006);

        // Clear wins over a simultaneous hit; c still follows the input.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clrhit_c", 32'(c2), 32'h1);
        chk("clrhit_cnt2", 32'(cnt2), 32'h0);
        chk("clrhit_cnt8", cnt8, 32'h0);
`endif

        // Async reset between edges.
        e = 1'b1;
        a = 2'd3;
        step();
        chk("pre_arst_c", 32'(c8), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_c8", 32'(c8), 32'h0);
        chk("arst_c2", 32'(c2), 32'h0);
`ifdef DEMUX_1_4_HIT_CNT_EN
        chk("arst_cnt8", cnt8, 32'h0);
`endif
        step();
        rst_n = 1'b1;
        a = 2'd1;
        step();
        chk("post_arst_c", 32'(c8), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux_1_4
